// File: rtl/fp_argmax_pkg.sv
// Shared types and float-format helpers for the sequential argmax/argmin selector.
package fp_argmax_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  // Widest float word the helpers accept; narrower formats are zero-extended.
  localparam int unsigned MAX_W = 64;
  typedef logic [MAX_W-1:0] word_t;

  function automatic int unsigned word_w(input int unsigned exp_w, input int unsigned man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int unsigned idx_w(input int unsigned n_ch);
    return (n_ch <= 1) ? 1 : $clog2(n_ch);
  endfunction

  function automatic logic is_nan(input word_t v, input int unsigned exp_w,
                                  input int unsigned man_w);
    word_t e_mask = (word_t'(1) << exp_w) - word_t'(1);
    word_t m_mask = (word_t'(1) << man_w) - word_t'(1);
    return (((v >> man_w) & e_mask) == e_mask) && ((v & m_mask) != '0);
  endfunction

  function automatic word_t quiet_nan(input int unsigned exp_w, input int unsigned man_w);
    word_t e_mask = (word_t'(1) << exp_w) - word_t'(1);
    return (e_mask << man_w) | (word_t'(1) << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_argmax_seq_if.sv
// Start/done request bundle carrying the packed channels and the selected result.
interface fp_argmax_seq_if
  import fp_argmax_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
);
  localparam int unsigned W     = word_w(EXP_W, MAN_W);
  localparam int unsigned IDX_W = idx_w(N_CH);

  logic              start;
  logic              sel_min;
  logic [N_CH*W-1:0] x_in;
  logic [W-1:0]      max;
  logic [IDX_W-1:0]  max_idx;
  logic              all_nan;
  logic              Done;

  modport master (output start, sel_min, x_in, input max, max_idx, all_nan, Done);
  modport slave  (input start, sel_min, x_in, output max, max_idx, all_nan, Done);
endinterface

// File: rtl/fp_compare.sv
// Combinational float ordering: a_wins when a strictly beats b; NaN never wins.
module fp_compare
  import fp_argmax_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  localparam int unsigned W    = word_w(EXP_W, MAN_W)
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sel_min,
  output logic         a_wins
);

  // Map sign-magnitude onto an unsigned key; both zeros share the +0 key.
  function automatic logic [W-1:0] order_key(input logic [W-1:0] v);
    logic [W-2:0] mag = v[W-2:0];
    if (mag == '0) return {1'b1, {(W-1){1'b0}}};
    return v[W-1] ? {1'b0, ~mag} : {1'b1, mag};
  endfunction

  logic         a_nan, b_nan;
  logic [W-1:0] a_key, b_key;

  assign a_nan = is_nan(word_t'(a), EXP_W, MAN_W);
  assign b_nan = is_nan(word_t'(b), EXP_W, MAN_W);
  assign a_key = order_key(a);
  assign b_key = order_key(b);

  always_comb begin
    a_wins = 1'b0;
    if (a_nan)        a_wins = 1'b0;
    else if (b_nan)   a_wins = 1'b1;
    else if (sel_min) a_wins = (a_key < b_key);
    else              a_wins = (a_key > b_key);
  end

endmodule

// File: rtl/fp_argmax_seq.sv
// Sequential max/min selector: captures N_CH floats on start, scans one channel per cycle.
module fp_argmax_seq
  import fp_argmax_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input logic            clk,
  input logic            rst,
  fp_argmax_seq_if.slave bus
);

  localparam int unsigned      W         = word_w(EXP_W, MAN_W);
  localparam int unsigned      IDX_W     = idx_w(N_CH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_CH - 1);
  localparam word_t            QNAN_FULL = quiet_nan(EXP_W, MAN_W);
  localparam logic [W-1:0]     QNAN      = QNAN_FULL[W-1:0];

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     ch_q [N_CH];
  logic [W-1:0]     ch_d [N_CH];
  logic             sel_min_q, sel_min_d;
  logic [W-1:0]     best_q, best_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     max_q, max_d;
  logic [IDX_W-1:0] max_idx_q, max_idx_d;
  logic             all_nan_q, all_nan_d;
  logic             done_q, done_d;

  logic [W-1:0]     cur_ch;
  logic             cur_wins;
  logic [W-1:0]     win_val;
  logic [IDX_W-1:0] win_idx;
  logic             finalize;

  assign cur_ch = ch_q[cnt_q];

  fp_compare #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cmp (
    .a       (cur_ch),
    .b       (best_q),
    .sel_min (sel_min_q),
    .a_wins  (cur_wins)
  );

  always_comb begin
    // NOTE: every variable gets a default up front so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    ch_d      = ch_q;
    sel_min_d = sel_min_q;
    best_d    = best_q;
    idx_d     = idx_q;
    max_d     = max_q;
    max_idx_d = max_idx_q;
    all_nan_d = all_nan_q;
    done_d    = done_q;
    win_val   = best_q;
    win_idx   = idx_q;
    finalize  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          for (int i = 0; i < N_CH; i++) ch_d[i] = bus.x_in[i*W +: W];
          sel_min_d = bus.sel_min;
          best_d    = bus.x_in[W-1:0];
          idx_d     = '0;
          done_d    = 1'b0;
          if (N_CH == 1) begin
            win_val  = bus.x_in[W-1:0];
            win_idx  = '0;
            finalize = 1'b1;
            cnt_d    = '0;
            state_d  = DONE;
          end else begin
            cnt_d   = IDX_W'(1);
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        if (cur_wins) begin
          best_d = cur_ch;
          idx_d  = cnt_q;
        end
        if (cnt_q == LAST_IDX) begin
          win_val  = best_d;
          win_idx  = idx_d;
          finalize = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        // Level-held start must drop before another capture is allowed.
        if (!bus.start) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // A surviving NaN best means no channel was an ordinary number.
    if (finalize) begin
      done_d = 1'b1;
      if (is_nan(word_t'(win_val), EXP_W, MAN_W)) begin
        max_d     = QNAN;
        max_idx_d = '0;
        all_nan_d = 1'b1;
      end else begin
        max_d     = win_val;
        max_idx_d = win_idx;
        all_nan_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      // NOTE: the capture array is cleared on reset too, so an aborted scan leaves no stale data.
      ch_q      <= '{default: '0};
      sel_min_q <= 1'b0;
      best_q    <= '0;
      idx_q     <= '0;
      max_q     <= '0;
      max_idx_q <= '0;
      all_nan_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking updates keep every flop sampling pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ch_q      <= ch_d;
      sel_min_q <= sel_min_d;
      best_q    <= best_d;
      idx_q     <= idx_d;
      max_q     <= max_d;
      max_idx_q <= max_idx_d;
      all_nan_q <= all_nan_d;
      done_q    <= done_d;
    end
  end

  assign bus.max     = max_q;
  assign bus.max_idx = max_idx_q;
  assign bus.all_nan = all_nan_q;
  assign bus.Done    = done_q;

endmodule

// File: tb/tb_fp_argmax_seq.sv
// Scoreboard bench for fp_argmax_seq with 4-, 1- and 7-channel instances.
module tb_fp_argmax_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  typedef struct {
    logic [31:0] val;
    logic [2:0]  idx;
    logic        nan;
    int          done_cyc;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];
  exp_t q7[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp_argmax_seq_if #(.N_CH(4)) b4 ();
  fp_argmax_seq_if #(.N_CH(1)) b1 ();
  fp_argmax_seq_if #(.N_CH(7)) b7 ();

  fp_argmax_seq #(.N_CH(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
  fp_argmax_seq #(.N_CH(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  fp_argmax_seq #(.N_CH(7)) dut7 (.clk(clk), .rst(rst), .bus(b7.slave));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic check_result(input string tag, input exp_t e, input logic [31:0] val,
                              input logic [2:0] idx, input logic nan);
    check({tag, "_max"},     64'(val), 64'(e.val));
    check({tag, "_idx"},     64'(idx), 64'(e.idx));
    check({tag, "_all_nan"}, 64'(nan), 64'(e.nan));
    check({tag, "_latency"}, 64'(cyc), 64'(e.done_cyc));
  endtask

  // Monitors: one result popped per rising Done
  logic prev4 = 1'b0, prev1 = 1'b0, prev7 = 1'b0;

  always @(negedge clk) begin
    if (b4.Done && !prev4) begin
      if (q4.size() == 0) begin
        n_checks++;
        $display("FAIL ch4_unexpected_done: got Done=1, required no result");
      end else check_result("ch4", q4.pop_front(), b4.max, 3'(b4.max_idx), b4.all_nan);
    end
    prev4 = b4.Done;
  end

  always @(negedge clk) begin
    if (b1.Done && !prev1) begin
      if (q1.size() == 0) begin
        n_checks++;
        $display("FAIL ch1_unexpected_done: got Done=1, required no result");
      end else check_result("ch1", q1.pop_front(), b1.max, 3'(b1.max_idx), b1.all_nan);
    end
    prev1 = b1.Done;
  end

  always @(negedge clk) begin
    if (b7.Done && !prev7) begin
      if (q7.size() == 0) begin
        n_checks++;
        $display("FAIL ch7_unexpected_done: got Done=1, required no result");
      end else check_result("ch7", q7.pop_front(), b7.max, 3'(b7.max_idx), b7.all_nan);
    end
    prev7 = b7.Done;
  end

  function automatic logic [223:0] v4(input logic [31:0] c0, c1, c2, c3);
    return {96'b0, c3, c2, c1, c0};
  endfunction

  function automatic logic [223:0] v7(input logic [31:0] c0, c1, c2, c3, c4, c5, c6);
    return {c6, c5, c4, c3, c2, c1, c0};
  endfunction

  task automatic set_start(input int which, input logic v);
    case (which)
      1:       b1.start = v;
      7:       b7.start = v;
      default: b4.start = v;
    endcase
  endtask

  task automatic set_in(input int which, input logic [223:0] x, input logic smin);
    case (which)
      1:       begin b1.x_in = x[31:0];  b1.sel_min = smin; end
      7:       begin b7.x_in = x;        b7.sel_min = smin; end
      default: begin b4.x_in = x[127:0]; b4.sel_min = smin; end
    endcase
  endtask

  function automatic logic done_of(input int which);
    case (which)
      1:       return b1.Done;
      7:       return b7.Done;
      default: return b4.Done;
    endcase
  endfunction

  // Issue one request, push its expectation, scramble inputs after capture, wait for Done.
  task automatic issue(input int which, input logic [223:0] x, input logic smin,
                       input logic [31:0] ev, input int ei, input logic en);
    int   n = (which == 1) ? 1 : (which == 7) ? 7 : 4;
    exp_t e;
    @(negedge clk);
    set_start(which, 1'b0);
    @(negedge clk);
    set_in(which, x, smin);
    set_start(which, 1'b1);
    e = '{ev, 3'(ei), en, cyc + n};
    case (which)
      1:       q1.push_back(e);
      7:       q7.push_back(e);
      default: q4.push_back(e);
    endcase
    @(negedge clk);
    set_in(which, ~x, ~smin);
    for (int t = 0; t < 40 && !done_of(which); t++) @(negedge clk);
    check("done_timeout", 64'(done_of(which)), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1);
  end

  initial begin
    b4.start = 1'b0; b4.sel_min = 1'b0; b4.x_in = '0;
    b1.start = 1'b0; b1.sel_min = 1'b0; b1.x_in = '0;
    b7.start = 1'b0; b7.sel_min = 1'b0; b7.x_in = '0;
    #1;
    check("rst_max",     64'(b4.max),     64'(0));
    check("rst_idx",     64'(b4.max_idx), 64'(0));
    check("rst_all_nan", 64'(b4.all_nan), 64'(0));
    check("rst_done",    64'(b4.Done),    64'(0));
    check("rst_done_1",  64'(b1.Done),    64'(0));
    check("rst_done_7",  64'(b7.Done),    64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Max of four positives, start held high through DONE
    issue(4, v4(32'h40133333, 32'h41151eb8, 32'h40466666, 32'h3f4ccccd), 1'b0,
          32'h41151eb8, 1, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("hold_done", 64'(b4.Done), 64'(1));
      check("hold_max",  64'(b4.max),  64'(32'h41151eb8));
    end
    set_start(4, 1'b0);
    @(negedge clk);
    check("idle_done_low", 64'(b4.Done),    64'(0));
    check("idle_max_kept", 64'(b4.max),     64'(32'h41151eb8));
    check("idle_idx_kept", 64'(b4.max_idx), 64'(1));

    issue(4, v4(32'h447a0000, 32'h4070a3d7, 32'h42466666, 32'h3f4ccccd), 1'b0,
          32'h447a0000, 0, 1'b0);
    issue(4, v4(32'h447a0000, 32'h4070a3d7, 32'h42466666, 32'h3f4ccccd), 1'b1,
          32'h3f4ccccd, 3, 1'b0);
    // Signed zeros tie; lower index keeps the win
    issue(4, v4(32'hbf800000, 32'h80000000, 32'h00000000, 32'hbf000000), 1'b0,
          32'h80000000, 1, 1'b0);
    issue(4, v4(32'hbf800000, 32'h80000000, 32'h00000000, 32'hbf000000), 1'b1,
          32'hbf800000, 0, 1'b0);
    // NaNs never win, infinities are ordinary extremes
    issue(4, v4(32'h7fc00000, 32'hff800000, 32'h7f800001, 32'hc2c80000), 1'b0,
          32'hc2c80000, 3, 1'b0);
    issue(4, v4(32'h7fc00000, 32'hff800000, 32'h7f800001, 32'hc2c80000), 1'b1,
          32'hff800000, 1, 1'b0);
    issue(4, v4(32'h00000001, 32'h7f800000, 32'h00000002, 32'hff800000), 1'b0,
          32'h7f800000, 1, 1'b0);
    issue(4, v4(32'h00000001, 32'h7f800000, 32'h00000002, 32'hff800000), 1'b1,
          32'hff800000, 3, 1'b0);
    // Denormals ordered by magnitude
    issue(4, v4(32'h00000003, 32'h00000001, 32'h80000001, 32'h00000002), 1'b1,
          32'h80000001, 2, 1'b0);
    issue(4, v4(32'h00000003, 32'h00000001, 32'h80000001, 32'h00000002), 1'b0,
          32'h00000003, 0, 1'b0);
    // All NaN gives the canonical quiet NaN
    issue(4, v4(32'h7fc00001, 32'h7fc00001, 32'h7fc00001, 32'h7fc00001), 1'b0,
          32'h7fc00000, 0, 1'b1);

    // Reset one cycle into the scan: outputs clear at once, no result appears
    @(negedge clk);
    set_start(4, 1'b0);
    @(negedge clk);
    set_in(4, v4(32'h40133333, 32'h41151eb8, 32'h40466666, 32'h3f4ccccd), 1'b0);
    set_start(4, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_max",     64'(b4.max),     64'(0));
    check("abort_idx",     64'(b4.max_idx), 64'(0));
    check("abort_all_nan", 64'(b4.all_nan), 64'(0));
    check("abort_done",    64'(b4.Done),    64'(0));
    set_start(4, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    issue(4, v4(32'h40133333, 32'h41151eb8, 32'h40466666, 32'h3f4ccccd), 1'b1,
          32'h3f4ccccd, 3, 1'b0);

    // Single channel: Done right after the capture edge
    issue(1, 224'(32'hc0000000), 1'b0, 32'hc0000000, 0, 1'b0);
    issue(1, 224'(32'hffffffff), 1'b1, 32'h7fc00000, 0, 1'b1);

    // Seven channels with a NaN and a tie between idx 5 and 6
    issue(7, v7(32'h3f800000, 32'h40000000, 32'hc0400000, 32'h40000000,
                32'h7fc00000, 32'h40800000, 32'h40800000), 1'b0, 32'h40800000, 5, 1'b0);
    issue(7, v7(32'h3f800000, 32'h40000000, 32'hc0400000, 32'h40000000,
                32'h7fc00000, 32'h40800000, 32'h40800000), 1'b1, 32'hc0400000, 2, 1'b0);

    repeat (3) @(negedge clk);
    check("queue4_drained", 64'(q4.size()), 64'(0));
    check("queue1_drained", 64'(q1.size()), 64'(0));
    check("queue7_drained", 64'(q7.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fp_argmax_seq.md
Name: fp_argmax_seq

Overview:
- Parametrised sequential IEEE-754 max/min selector. It is the next-generation output stage of the neural-network datapath: the current stage is fixed at four 32-bit channels.
- Captures N_CH floating-point channel values on a start request and scans them one channel per cycle. Returns the winning value, its channel index and a validity flag under a start/done handshake.
- Adds a runtime min/max mode and defined NaN and tie handling.

Parameters:
- N_CH, 4, number of input channels (>=1).
- EXP_W, 8, exponent width of the float format.
- MAN_W, 23, mantissa width. Word width W = 1+EXP_W+MAN_W (32 by default).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request; level-sampled in IDLE.
- sel_min  in  1  0 = find maximum, 1 = find minimum; captured with the data.
- x_in  in  N_CH*W  packed channels; channel i occupies x_in[i*W +: W].
- max  out  W  winning value (minimum when sel_min=1).
- max_idx  out  IDX_W  channel index of the winner; IDX_W = max(1, clog2(N_CH)).
- all_nan  out  1  every captured channel was NaN.
- Done  out  1  result valid (level).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, max=0, max_idx=0, all_nan=0, Done=0, counter=0, capture registers cleared. Reset mid-scan aborts the scan with no partial result.
- States:
  - IDLE: on an edge with start=1, capture x_in and sel_min, set best=ch0, idx=0, cnt=1, Done=0. Go to SCAN, or directly to DONE if N_CH=1.
  - SCAN: each edge compares ch[cnt] against best and replaces best/idx if ch[cnt] wins; cnt++. The edge that processes cnt=N_CH-1 registers the final outputs and enters DONE.
  - DONE: Done=1 and outputs held stable. Return to IDLE only on an edge with start=0; a continuously high start never re-triggers. Outputs keep their last values in IDLE; Done drops.
- Latency: with the start edge k, Done is high after edge k+N_CH-1 (3 cycles for N_CH=4). Input changes after edge k are ignored.
- Ordering rules:
  - Sign-magnitude float order.
  - ±Inf are ordinary extremes.
  - Denormals are ordered by magnitude.
  - +0 and -0 compare equal.
  - NaN (exponent all ones, mantissa nonzero) never wins and is always replaced by any non-NaN value.
- Ties: the lower index wins. Replacement requires strictly greater (max) or strictly less (min).
- All NaN: max = canonical quiet NaN (sign 0, exponent all ones, mantissa MSB 1, rest 0; 0x7FC00000 for the default format), max_idx=0, all_nan=1. Otherwise all_nan=0.
- The counter wraps only via reload in IDLE; cnt never exceeds N_CH-1.

Decomposition:
- Package fp_argmax_pkg holds:
  - the state enum (IDLE, SCAN, DONE);
  - the W and IDX_W helper functions, including the N_CH=1 guard;
  - an is_nan function;
  - the quiet-NaN constant builder.
- Sub-module fp_compare (combinational): inputs a, b, sel_min; output a_wins = a strictly beats b under the rules above, with NaN handling included. It is instanced once, on ch[cnt] versus best.

Test Plan:
- x = {2.30 0x40133333, 9.32 0x41151eb8, 3.1 0x40466666, 0.8 0x3f4ccccd}, sel_min=0, start held high → Done high 3 cycles after capture, max=0x41151eb8, max_idx=1. Done stays high while start=1.
- start low then high with x = {0x447a0000, 0x4070a3d7, 0x42466666, 0x3f4ccccd} → max=0x447a0000, max_idx=0. Repeat with sel_min=1 → max=0x3f4ccccd, max_idx=3.
- x = {0xBF800000 (-1.0), 0x80000000 (-0), 0x00000000 (+0), 0xBF000000 (-0.5)}, max mode → max=0x80000000, max_idx=1 (tie, lower index wins).
- x = {0x7FC00000, 0xFF800000 (-Inf), 0x7F800001, 0xC2C80000 (-100)}, max mode → max=0xC2C80000, idx=3, all_nan=0. All four channels 0x7FC00001 → max=0x7FC00000, idx=0, all_nan=1.
- Drive rst=0 one cycle after a start capture → outputs immediately 0 and state IDLE. After release and a fresh start, the correct result is produced.
- Change x_in during SCAN → result reflects the captured values only. Bench variants with N_CH=1 (Done one edge after start, idx=0) and N_CH=7 (latency 6 cycles).
